// File: rtl/adc_sample_reader_pkg.sv
// Shared constants and FSM state encoding for the ADC sample reader.
// Build macro ADC_SAMPLE_AVG_EN (top level) enables 4-sample averaging.
package adc_sample_reader_pkg;

  localparam int ADC_DATA_W = 16;
  localparam int ADC_BITS   = 16;
  localparam int ACC_W      = 18;
  localparam int RISE_CNT_W = $clog2(ADC_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONVST = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/adc_sample_reader_sclk_gen.sv
// Serial clock generator: divides clk by CLK_DIV per half-period while run is high,
// strobes each sclk rise, and flags the falling edge that follows the last rise.
module adc_sample_reader_sclk_gen
  import adc_sample_reader_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]      div_cnt_r;
  logic [RISE_CNT_W-1:0] rise_cnt_r;
  logic                  sclk_r;
  logic                  toggle_s;

  assign toggle_s   = run && (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign rise       = toggle_s && !sclk_r;
  assign frame_done = toggle_s && sclk_r && (rise_cnt_r == RISE_CNT_W'(ADC_BITS));
  assign sclk       = sclk_r;

  // Divider, sclk level and rise count; everything restarts whenever run drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_r  <= '0;
      rise_cnt_r <= '0;
      sclk_r     <= 1'b0;
    end else if (!run) begin
      div_cnt_r  <= '0;
      rise_cnt_r <= '0;
      sclk_r     <= 1'b0;
    end else if (toggle_s) begin
      div_cnt_r <= '0;
      sclk_r    <= !sclk_r;
      if (!sclk_r) begin
        rise_cnt_r <= rise_cnt_r + RISE_CNT_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/adc_sample_reader.sv
// Periodic ADC conversion sequencer: convst pulse, conversion wait, 16-bit serial read.
// Define ADC_SAMPLE_AVG_EN to publish the truncated mean of every four conversions.
module adc_sample_reader
  import adc_sample_reader_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 4,
  parameter int CONV_WAIT     = 50,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  clear_overrun,
  input  logic                  adc_sdo,
  output logic                  adc_convst,
  output logic                  adc_csn,
  output logic                  adc_sclk,
  output logic [ADC_DATA_W-1:0] adc_data,
  output logic                  adc_data_valid,
  output logic                  busy,
  output logic                  sample_overrun
);

  localparam int PER_W    = $clog2(SAMPLE_PERIOD);
  localparam int STEP_MAX = (CONVST_CYCLES > CONV_WAIT) ? CONVST_CYCLES : CONV_WAIT;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  state_t                state_r, state_n;
  logic [PER_W-1:0]      per_cnt_r;
  logic [STEP_W-1:0]     step_cnt_r, step_cnt_n;
  logic [ADC_BITS-1:0]   shift_r;
  logic [ADC_DATA_W-1:0] data_r;
  logic                  tick_s, sclk_rise_s, frame_done_s;
  logic                  convst_r, csn_r, valid_r, busy_r, overrun_r;

  adc_sample_reader_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk        (clk),
    .rstn       (rstn),
    .run        (state_r == ST_SHIFT),
    .sclk       (adc_sclk),
    .rise       (sclk_rise_s),
    .frame_done (frame_done_s)
  );

  // Period counter rests at zero while disabled, so the first enabled cycle ticks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      per_cnt_r <= '0;
    end else if (!enable || (per_cnt_r == PER_W'(SAMPLE_PERIOD - 1))) begin
      per_cnt_r <= '0;
    end else begin
      per_cnt_r <= per_cnt_r + PER_W'(1);
    end
  end

  assign tick_s = enable && (per_cnt_r == '0);

  // Next-state and phase counter.
  always_comb begin
    state_n    = state_r;
    step_cnt_n = step_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_n    = ST_CONVST;
          step_cnt_n = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CONVST: begin
        if (step_cnt_r == STEP_W'(CONVST_CYCLES - 1)) begin
          state_n    = ST_WAIT;
          step_cnt_n = '0;
        end else begin
          step_cnt_n = step_cnt_r + STEP_W'(1);
        end
      end
      ST_WAIT: begin
        if (step_cnt_r == STEP_W'(CONV_WAIT - 1)) begin
          state_n    = ST_SHIFT;
          step_cnt_n = '0;
        end else begin
          step_cnt_n = step_cnt_r + STEP_W'(1);
        end
      end
      ST_SHIFT: begin
        if (frame_done_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: begin
        state_n    = ST_IDLE;
        step_cnt_n = '0;
      end
    endcase
  end

  // State plus pin outputs, registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      step_cnt_r <= '0;
      convst_r   <= 1'b0;
      csn_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      step_cnt_r <= step_cnt_n;
      convst_r   <= (state_n == ST_CONVST);
      csn_r      <= (state_n != ST_SHIFT);
      busy_r     <= (state_n != ST_IDLE);
    end
  end

  // Shift register captures sdo on the cycle that raises sclk, MSB first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_r <= '0;
    end else if (sclk_rise_s) begin
      shift_r <= {shift_r[ADC_BITS-2:0], adc_sdo};
    end
  end

  // Overrun is sticky; a new overrun outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_r <= 1'b0;
    end else if (tick_s && (state_r != ST_IDLE)) begin
      overrun_r <= 1'b1;
    end else if (clear_overrun) begin
      overrun_r <= 1'b0;
    end
  end

`ifdef ADC_SAMPLE_AVG_EN
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_sum_s;
  logic [1:0]       avg_cnt_r;
  logic             enable_d_r;

  assign acc_sum_s = acc_r + ACC_W'(shift_r);

  // Accumulate four conversions, publish sum/4, restart on enable fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r      <= '0;
      avg_cnt_r  <= 2'd0;
      enable_d_r <= 1'b0;
      data_r     <= '0;
      valid_r    <= 1'b0;
    end else begin
      enable_d_r <= enable;
      valid_r    <= 1'b0;
      if (state_n == ST_DONE) begin
        if (avg_cnt_r == 2'd3) begin
          data_r    <= acc_sum_s[ACC_W-1:2];
          valid_r   <= 1'b1;
          acc_r     <= '0;
          avg_cnt_r <= 2'd0;
        end else begin
          acc_r     <= acc_sum_s;
          avg_cnt_r <= avg_cnt_r + 2'd1;
        end
      end else if (enable_d_r && !enable) begin
        acc_r     <= '0;
        avg_cnt_r <= 2'd0;
      end
    end
  end
`else
  // Every completed frame is published for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= (state_n == ST_DONE);
      if (state_n == ST_DONE) begin
        data_r <= shift_r;
      end
    end
  end
`endif

  assign adc_convst     = convst_r;
  assign adc_csn        = csn_r;
  assign adc_data       = data_r;
  assign adc_data_valid = valid_r;
  assign busy           = busy_r;
  assign sample_overrun = overrun_r;

endmodule
